frame_generator: RTL and testbench
==================================

FRAME_GENERATOR -- requirements
Module: frame_generator

Interface
REQ-001 SHALL have parameter NB_DATA_RAW, default 64, raw data block width in bits.
REQ-002 SHALL have parameter NB_CTRL_RAW, default 8, raw control flag width, one flag per byte.
REQ-003 SHALL have parameter NB_BYTE, default 8, lane byte width.
REQ-004 SHALL have parameter NB_LEN, default 8, width of burst and gap length inputs.
REQ-005 SHALL have parameter NB_DATA_COUNTER, default 32, width of the data-block counter.
REQ-006 SHALL have port i_clock  input  1  rising-edge clock.
REQ-007 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_enable  input  1  clock enable; all state advances only when high.
REQ-009 SHALL have port i_burst_len  input  NB_LEN  data blocks per burst; 0 = continuous data.
REQ-010 SHALL have port i_gap_len  input  NB_LEN  idle blocks per gap; 0 = no gap.
REQ-011 SHALL have port o_tx_raw_data  output  NB_DATA_RAW  registered raw data block.
REQ-012 SHALL have port o_tx_raw_ctrl  output  NB_CTRL_RAW  registered per-byte control flags.
REQ-013 SHALL have port o_data_count  output  NB_DATA_COUNTER  total data blocks emitted.

Function
REQ-014 SHALL implement two states: ST_DATA (emit pattern blocks) and ST_GAP (emit idle blocks).
REQ-015 SHALL hold an NB_BYTE pattern register and an NB_LEN block counter blk_cnt.
REQ-016 SHALL, on an enabled edge in ST_DATA, load o_tx_raw_data with the pattern replicated into all NB_DATA_RAW/NB_BYTE bytes, o_tx_raw_ctrl with all zeros, increment pattern, increment o_data_count.
REQ-017 SHALL, on an enabled edge in ST_GAP, load o_tx_raw_data with 0x07 in every byte, o_tx_raw_ctrl with all ones; pattern and o_data_count hold.
REQ-018 SHALL wrap pattern 0xFF -> 0x00 and o_data_count all-ones -> 0, with no saturation.
REQ-019 SHALL, in ST_DATA, move to ST_GAP with blk_cnt <= 0 when i_burst_len != 0, i_gap_len != 0 and blk_cnt+1 >= i_burst_len; otherwise increment blk_cnt and stay.
REQ-020 SHALL, in ST_DATA with i_burst_len == 0 or i_gap_len == 0, remain in ST_DATA indefinitely, with blk_cnt held at 0.
REQ-021 SHALL, in ST_GAP, move to ST_DATA with blk_cnt <= 0 when blk_cnt+1 >= i_gap_len; otherwise increment blk_cnt.
REQ-022 SHALL compare against live i_burst_len/i_gap_len each cycle, so a length lowered mid-burst below blk_cnt+1 ends that burst or gap on the next enabled edge.
REQ-023 SHALL hold all registers and outputs unchanged when i_enable is low.
REQ-024 SHALL have one cycle latency from an enabled edge to the corresponding block on the outputs.
REQ-025 SHALL produce a stream that a downstream checker, skipping blocks with any ctrl flag set, sees as consecutive data blocks whose pattern increments by exactly 1.

Reset
REQ-026 SHALL, while i_reset is high at a clock edge, override i_enable and set state to ST_DATA, blk_cnt to 0, pattern to 0x00, o_data_count to 0, o_tx_raw_data to 0x0707...07, and o_tx_raw_ctrl to all ones.
REQ-027 SHALL make the first enabled edge after reset emit a data block of all 0x00 bytes.
REQ-028 SHALL, on reset asserted mid-burst or mid-gap, abandon the sequence and restart from REQ-026 values.

Configuration
REQ-029 SHALL, with macro FRAME_GEN_ERR_INJECT_EN defined, add port i_inject_err (input, 1 bit); on an enabled ST_DATA edge with i_inject_err high, the most-significant byte of o_tx_raw_data is XORed with 0x01, while pattern and o_data_count advance normally.
REQ-030 SHALL, without FRAME_GEN_ERR_INJECT_EN, have no i_inject_err port and no corruption logic.

Verification
REQ-031 SHALL cover: reset, i_enable=1, burst 4, gap 2 -> data 0x00..0x03 (ctrl 0x00), 2 idle blocks (0x07 bytes, ctrl 0xFF), then data 0x04.
REQ-032 SHALL cover: burst 0, gap 3, 300 enabled cycles -> continuous data, pattern wraps 0xFF -> 0x00, o_data_count = 300.
REQ-033 SHALL cover: i_enable toggled low for 5 cycles mid-burst -> outputs and o_data_count frozen, sequence resumes without skipping any pattern value.
REQ-034 SHALL cover: burst 10 lowered to 2 when blk_cnt = 5 -> ST_GAP entered on the next enabled edge.
REQ-035 SHALL cover: i_reset pulsed mid-gap -> idle block with ctrl 0xFF output, then the next enabled data block is 0x00.
REQ-036 SHALL cover, with FRAME_GEN_ERR_INJECT_EN: i_inject_err high on pattern 0x10 -> block 0x11 followed by seven 0x10 bytes, and the next data block is 0x11 uncorrupted.

Source files
------------

// File: rtl/frame_generator.sv
// Frame generator: bursts of incrementing-pattern data blocks separated by idle gaps (error injection via FRAME_GEN_ERR_INJECT_EN).
// One-cycle registered latency; no backpressure, i_enable low freezes every register.
module frame_generator #(
  parameter int NB_DATA_RAW     = 64,
  parameter int NB_CTRL_RAW     = 8,
  parameter int NB_BYTE         = 8,
  parameter int NB_LEN          = 8,
  parameter int NB_DATA_COUNTER = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [NB_LEN-1:0]          i_burst_len,
  input  logic [NB_LEN-1:0]          i_gap_len,
`ifdef FRAME_GEN_ERR_INJECT_EN
  input  logic                       i_inject_err,
`endif
  output logic [NB_DATA_RAW-1:0]     o_tx_raw_data,
  output logic [NB_CTRL_RAW-1:0]     o_tx_raw_ctrl,
  output logic [NB_DATA_COUNTER-1:0] o_data_count
);

  localparam int N_LANES = NB_DATA_RAW / NB_BYTE;
  localparam logic [NB_BYTE-1:0] IDLE_BYTE = NB_BYTE'(8'h07);

  typedef enum logic {ST_DATA = 1'b0, ST_GAP = 1'b1} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [NB_LEN-1:0]          r_blk_cnt;
  logic [NB_LEN-1:0]          w_blk_cnt_next;
  logic [NB_LEN:0]            w_blk_cnt_inc;
  logic [NB_BYTE-1:0]         r_pattern;
  logic [NB_BYTE-1:0]         w_pattern_next;
  logic [NB_DATA_RAW-1:0]     r_tx_raw_data;
  logic [NB_DATA_RAW-1:0]     w_data_next;
  logic [NB_CTRL_RAW-1:0]     r_tx_raw_ctrl;
  logic [NB_CTRL_RAW-1:0]     w_ctrl_next;
  logic [NB_DATA_COUNTER-1:0] r_data_count;
  logic [NB_DATA_COUNTER-1:0] w_count_next;

  // One extra bit so blk_cnt+1 never wraps before the length compare.
  assign w_blk_cnt_inc = {1'b0, r_blk_cnt} + (NB_LEN + 1)'(1);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_DATA;
    end else if (i_enable) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_blk_cnt_next = r_blk_cnt;
    w_pattern_next = r_pattern;
    w_count_next   = r_data_count;
    w_data_next    = {N_LANES{IDLE_BYTE}};
    w_ctrl_next    = {NB_CTRL_RAW{1'b1}};
    case (r_state)
      ST_DATA: begin
        w_data_next    = {N_LANES{r_pattern}};
        w_ctrl_next    = '0;
        w_pattern_next = r_pattern + NB_BYTE'(1);
        w_count_next   = r_data_count + NB_DATA_COUNTER'(1);
`ifdef FRAME_GEN_ERR_INJECT_EN
        if (i_inject_err) begin
          w_data_next[NB_DATA_RAW-1 -: NB_BYTE] = r_pattern ^ NB_BYTE'(1);
        end
`endif
        if (i_burst_len == '0 || i_gap_len == '0) begin
          w_blk_cnt_next = '0;
        end else if (w_blk_cnt_inc >= {1'b0, i_burst_len}) begin
          w_state_next   = ST_GAP;
          w_blk_cnt_next = '0;
        end else begin
          w_blk_cnt_next = w_blk_cnt_inc[NB_LEN-1:0];
        end
      end
      ST_GAP: begin
        if (w_blk_cnt_inc >= {1'b0, i_gap_len}) begin
          w_state_next   = ST_DATA;
          w_blk_cnt_next = '0;
        end else begin
          w_blk_cnt_next = w_blk_cnt_inc[NB_LEN-1:0];
        end
      end
      default: begin
        w_state_next   = ST_DATA;
        w_blk_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_blk_cnt     <= '0;
      r_pattern     <= '0;
      r_data_count  <= '0;
      r_tx_raw_data <= {N_LANES{IDLE_BYTE}};
      r_tx_raw_ctrl <= {NB_CTRL_RAW{1'b1}};
    end else if (i_enable) begin
      r_blk_cnt     <= w_blk_cnt_next;
      r_pattern     <= w_pattern_next;
      r_data_count  <= w_count_next;
      r_tx_raw_data <= w_data_next;
      r_tx_raw_ctrl <= w_ctrl_next;
    end
  end

  assign o_tx_raw_data = r_tx_raw_data;
  assign o_tx_raw_ctrl = r_tx_raw_ctrl;
  assign o_data_count  = r_data_count;

endmodule

// File: tb/tb_frame_generator.sv
// Directed bench for frame_generator; define FRAME_GEN_ERR_INJECT_EN to also exercise error injection.
module tb_frame_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  burst_len;
  logic [7:0]  gap_len;
  logic        inject_err;
  logic [63:0] data;
  logic [7:0]  ctrl;
  logic [31:0] count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IDLE = 64'h0707070707070707;

  always #5 clk = ~clk;

  frame_generator dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_burst_len  (burst_len),
    .i_gap_len    (gap_len),
`ifdef FRAME_GEN_ERR_INJECT_EN
    .i_inject_err (inject_err),
`endif
    .o_tx_raw_data(data),
    .o_tx_raw_ctrl(ctrl),
    .o_data_count (count)
  );

  function automatic logic [63:0] rep(input logic [7:0] p);
    return {8{p}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; burst_len = 8'd4; gap_len = 8'd2; inject_err = 1'b0;
    do_reset();
    checks++;
    if (data !== IDLE) begin errors++; $display("FAIL reset_data actual=%h required=%h", data, IDLE); end
    checks++;
    if (ctrl !== 8'hFF) begin errors++; $display("FAIL reset_ctrl actual=%h required=ff", ctrl); end
    checks++;
    if (count !== 32'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", count); end
  endtask

  task automatic test_burst_gap();
    logic [63:0] exp_d [7];
    logic [7:0]  exp_c [7];
    exp_d = '{rep(8'h00), rep(8'h01), rep(8'h02), rep(8'h03), IDLE, IDLE, rep(8'h04)};
    exp_c = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    en = 1'b1; burst_len = 8'd4; gap_len = 8'd2;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (data !== exp_d[i] || ctrl !== exp_c[i]) begin
        errors++;
        $display("FAIL burst_gap blk%0d actual=%h/%h required=%h/%h", i, data, ctrl, exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (count !== 32'd5) begin errors++; $display("FAIL burst_gap_count actual=%0d required=5", count); end
  endtask

  task automatic test_continuous();
    logic [7:0] p;
    int bad = 0;
    en = 1'b1; burst_len = 8'd0; gap_len = 8'd3;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step();
      p = 8'(i);
      checks++;
      if (data !== rep(p) || ctrl !== 8'h00) begin
        errors++;
        if (bad < 5) $display("FAIL continuous blk%0d actual=%h/%h required=%h/00", i, data, ctrl, rep(p));
        bad++;
      end
    end
    checks++;
    if (count !== 32'd300) begin errors++; $display("FAIL continuous_count actual=%0d required=300", count); end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; burst_len = 8'd10; gap_len = 8'd2;
    do_reset();
    repeat (3) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (data !== rep(8'h02) || ctrl !== 8'h00 || count !== 32'd3) begin
        errors++;
        $display("FAIL enable_hold cyc%0d actual=%h/%h/%0d required=%h/00/3", i, data, ctrl, count, rep(8'h02));
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (data !== rep(8'h03) || count !== 32'd4) begin
      errors++;
      $display("FAIL enable_resume actual=%h/%0d required=%h/4", data, count, rep(8'h03));
    end
  endtask

  task automatic test_len_lowered();
    en = 1'b1; burst_len = 8'd10; gap_len = 8'd2;
    do_reset();
    repeat (5) step();
    burst_len = 8'd2;
    step();
    checks++;
    if (data !== rep(8'h05) || ctrl !== 8'h00) begin
      errors++;
      $display("FAIL lowered_last_data actual=%h/%h required=%h/00", data, ctrl, rep(8'h05));
    end
    step();
    checks++;
    if (data !== IDLE || ctrl !== 8'hFF) begin
      errors++;
      $display("FAIL lowered_gap actual=%h/%h required=%h/ff", data, ctrl, IDLE);
    end
    checks++;
    if (count !== 32'd6) begin errors++; $display("FAIL lowered_count actual=%0d required=6", count); end
  endtask

  task automatic test_reset_mid_gap();
    en = 1'b1; burst_len = 8'd2; gap_len = 8'd3;
    do_reset();
    repeat (3) step();
    checks++;
    if (ctrl !== 8'hFF) begin errors++; $display("FAIL midgap_pre actual=%h required=ff", ctrl); end
    rst = 1'b1;
    step();
    checks++;
    if (data !== IDLE || ctrl !== 8'hFF || count !== 32'd0) begin
      errors++;
      $display("FAIL midgap_reset actual=%h/%h/%0d required=%h/ff/0", data, ctrl, count, IDLE);
    end
    rst = 1'b0;
    step();
    checks++;
    if (data !== rep(8'h00) || ctrl !== 8'h00 || count !== 32'd1) begin
      errors++;
      $display("FAIL midgap_restart actual=%h/%h/%0d required=%h/00/1", data, ctrl, count, rep(8'h00));
    end
  endtask

`ifdef FRAME_GEN_ERR_INJECT_EN
  task automatic test_inject();
    en = 1'b1; burst_len = 8'd0; gap_len = 8'd0; inject_err = 1'b0;
    do_reset();
    repeat (16) step();
    inject_err = 1'b1;
    step();
    checks++;
    if (data !== 64'h1110101010101010 || count !== 32'd17) begin
      errors++;
      $display("FAIL inject_blk actual=%h/%0d required=1110101010101010/17", data, count);
    end
    inject_err = 1'b0;
    step();
    checks++;
    if (data !== rep(8'h11) || count !== 32'd18) begin
      errors++;
      $display("FAIL inject_next actual=%h/%0d required=%h/18", data, count, rep(8'h11));
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; burst_len = '0; gap_len = '0; inject_err = 1'b0;
    test_reset();
    test_burst_gap();
    test_continuous();
    test_enable_hold();
    test_len_lowered();
    test_reset_mid_gap();
`ifdef FRAME_GEN_ERR_INJECT_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
